// File: rtl/mem_access_unit.sv
// Load/store initiator between CPU datapath and byte memory; aligned accesses take one
// memory cycle, misaligned ones are split into ascending byte cycles (or rejected).
module mem_access_unit #(
    parameter bit SPLIT_UNALIGNED = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    output logic        o_ready,
    input  logic        i_write,
    input  logic [15:0] i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic [15:0] o_maddr,
    output logic [31:0] o_mdata,
    output logic [1:0]  o_msize,
    output logic        o_mwe,
    input  logic [31:0] i_mdata
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t      state, state_nxt;
    logic        write_r, sgn_r;
    logic [15:0] addr_r;
    logic [1:0]  size_r;
    logic [31:0] wdata_r;
    logic [1:0]  k_r;
    logic [1:0]  last_r;
    logic [31:0] asm_r, asm_nxt;
    logic        done_r, err_r;
    logic [31:0] rdata_r;

    logic        accept, is_half, is_word, misaligned, reject;
    logic [31:0] load_raw;

    assign accept     = i_req && (state == IDLE);
    assign is_half    = (i_size == 2'b01) || (i_size == 2'b10);
    assign is_word    = (i_size == 2'b11);
    assign misaligned = (is_half && i_addr[0]) || (is_word && (i_addr[1:0] != 2'b00));
    assign reject     = misaligned && !SPLIT_UNALIGNED;

    assign o_ready = (state == IDLE);
    assign o_done  = done_r;
    assign o_err   = err_r;
    assign o_rdata = rdata_r;

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] sz,
                                           input logic sgn);
        logic [31:0] r;
        case (sz)
            2'b00:        r = {{24{sgn & raw[7]}}, raw[7:0]};
            2'b01, 2'b10: r = {{16{sgn & raw[15]}}, raw[15:0]};
            default:      r = raw;
        endcase
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = reject ? RESP : XFER;
            XFER: if (k_r == last_r) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // last_r == 0 marks a single full-width cycle; otherwise byte k_r of a split access
    always_comb begin
        o_maddr = 16'h0000;
        o_mdata = 32'h0000_0000;
        o_msize = 2'b00;
        o_mwe   = 1'b1;
        if (state == XFER) begin
            o_mwe = ~write_r;
            if (last_r == 2'd0) begin
                o_maddr = addr_r;
                o_msize = size_r;
                o_mdata = wdata_r;
            end else begin
                o_maddr = addr_r + {14'd0, k_r};
                o_mdata = {24'd0, wdata_r[{k_r, 3'b000} +: 8]};
            end
        end
    end

    always_comb begin
        asm_nxt = asm_r;
        asm_nxt[{k_r, 3'b000} +: 8] = i_mdata[7:0];
        load_raw = (last_r == 2'd0) ? i_mdata : asm_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            write_r <= 1'b0;
            sgn_r   <= 1'b0;
            addr_r  <= 16'h0000;
            size_r  <= 2'b00;
            wdata_r <= 32'h0000_0000;
            k_r     <= 2'd0;
            last_r  <= 2'd0;
            asm_r   <= 32'h0000_0000;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        write_r <= i_write;
                        sgn_r   <= i_signed;
                        addr_r  <= i_addr;
                        size_r  <= i_size;
                        wdata_r <= i_wdata;
                        k_r     <= 2'd0;
                        asm_r   <= 32'h0000_0000;
                        if (misaligned && SPLIT_UNALIGNED)
                            last_r <= is_word ? 2'd3 : 2'd1;
                        else
                            last_r <= 2'd0;
                        if (reject) begin
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                            rdata_r <= 32'h0000_0000;
                        end
                    end
                end
                XFER: begin
                    if (!write_r) asm_r <= asm_nxt;
                    k_r <= k_r + 2'd1;
                    if (k_r == last_r) begin
                        done_r  <= 1'b1;
                        err_r   <= 1'b0;
                        rdata_r <= write_r ? 32'h0000_0000 : extend(load_raw, size_r, sgn_r);
                    end
                end
                default: begin
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte memory model on the port, directed and random
// loads/stores compared against an operation-level reference memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, write = 1'b0, sgn = 1'b0;
    logic [15:0] addr = '0;
    logic [1:0]  size = '0;
    logic [31:0] wdata = '0;
    logic        ready, done, err, mwe;
    logic [31:0] rdata, mdata, mrd;
    logic [15:0] maddr;
    logic [1:0]  msize;

    logic        req0 = 1'b0, write0 = 1'b0, sgn0 = 1'b0;
    logic [15:0] addr0 = '0;
    logic [1:0]  size0 = '0;
    logic        ready0, done0, err0, mwe0;
    logic [31:0] rdata0, mdata0;
    logic [15:0] maddr0;
    logic [1:0]  msize0;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0]  mem [0:65535];
    bit          mem_vld [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] trace[$];
    logic [31:0] last_rdata;
    int          last_lat;

    always #5 clk = ~clk;

    mem_access_unit #(.SPLIT_UNALIGNED(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_ready(ready), .i_write(write),
        .i_addr(addr), .i_size(size), .i_signed(sgn), .i_wdata(wdata), .o_done(done),
        .o_rdata(rdata), .o_err(err), .o_maddr(maddr), .o_mdata(mdata), .o_msize(msize),
        .o_mwe(mwe), .i_mdata(mrd));

    mem_access_unit #(.SPLIT_UNALIGNED(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .o_ready(ready0), .i_write(write0),
        .i_addr(addr0), .i_size(size0), .i_signed(sgn0), .i_wdata(32'h0), .o_done(done0),
        .o_rdata(rdata0), .o_err(err0), .o_maddr(maddr0), .o_mdata(mdata0), .o_msize(msize0),
        .o_mwe(mwe0), .i_mdata(32'hDEAD_BEEF));

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return (a[7:0] * 8'd29) ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] rd_mem(input logic [15:0] a);
        return mem_vld[a] ? mem[a] : init_byte(a);
    endfunction

    // Memory model: combinational read, write of msize bytes on the edge ending a cycle
    always_comb begin
        mrd = {rd_mem(maddr + 16'd3), rd_mem(maddr + 16'd2), rd_mem(maddr + 16'd1), rd_mem(maddr)};
        case (msize)
            2'b00:        mrd[31:8] = 24'h0;
            2'b01, 2'b10: mrd[31:16] = 16'h0;
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (!mwe) begin
            for (int j = 0; j < ((msize == 2'b00) ? 1 : (msize == 2'b11) ? 4 : 2); j++) begin
                mem[16'(maddr + 16'(j))]     <= mdata[8*j +: 8];
                mem_vld[16'(maddr + 16'(j))] <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic w, input logic [15:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd);
        int n, exp_lat, lat, wcyc;
        logic mis;
        logic [31:0] exp_rd;
        n = (sz == 2'b00) ? 1 : (sz == 2'b11) ? 4 : 2;
        mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        exp_lat = mis ? n + 1 : 2;
        @(negedge clk);
        check("idle_ready", {31'd0, ready}, 32'd1);
        check("idle_nodone", {31'd0, done}, 32'd0);
        req = 1'b1; write = w; addr = a; size = sz; sgn = sg; wdata = wd;
        @(posedge clk);
        #1;
        req = 1'b0; write = 1'($urandom); addr = 16'($urandom); size = 2'($urandom);
        sgn = 1'($urandom); wdata = $urandom;
        trace.delete();
        lat = 0; wcyc = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (done) break;
            trace.push_back(maddr);
            if (!mwe) wcyc++;
        end
        last_lat = lat; last_rdata = rdata;
        check("latency", lat, exp_lat);
        check("write_cycles", wcyc, w ? exp_lat - 1 : 0);
        check("err_clear", {31'd0, err}, 32'd0);
        for (int i = 0; i < trace.size() && i < n; i++)
            check("maddr_seq", {16'd0, trace[i]}, {16'd0, mis ? 16'(a + 16'(i)) : a});
        exp_rd = 32'h0;
        if (w) begin
            for (int j = 0; j < n; j++) ref_mem[16'(a + 16'(j))] = wd[8*j +: 8];
            for (int j = 0; j < n; j++)
                check("mem_byte", {24'd0, rd_mem(16'(a + 16'(j)))}, {24'd0, ref_mem[16'(a + 16'(j))]});
        end else begin
            for (int j = 0; j < n; j++) exp_rd = exp_rd + (32'(ref_mem[16'(a + 16'(j))]) << (8 * j));
            if (sg && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | ~((32'd1 << (8 * n)) - 32'd1);
        end
        check("rdata", rdata, exp_rd);
    endtask

    initial begin
        logic [31:0] wd;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
        #12;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_mwe", {31'd0, mwe}, 32'd1);
        check("rst_maddr", {16'd0, maddr}, 32'd0);
        check("rst_msize", {30'd0, msize}, 32'd0);
        check("rst_mdata", mdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(1'b1, 16'h0010, 2'b11, 1'b0, 32'h1122_3344);
        check("w10_byte0", {24'd0, rd_mem(16'h0010)}, 32'h44);
        check("w10_byte3", {24'd0, rd_mem(16'h0013)}, 32'h11);
        do_op(1'b0, 16'h0010, 2'b11, 1'b0, 32'h0);
        check("ld10_value", last_rdata, 32'h1122_3344);
        check("ld10_lat", last_lat, 2);

        do_op(1'b1, 16'h0000, 2'b11, 1'b0, 32'h0302_0100);
        do_op(1'b1, 16'h0004, 2'b11, 1'b0, 32'h0706_0504);
        do_op(1'b0, 16'h0003, 2'b11, 1'b0, 32'h0);
        check("ld3_value", last_rdata, 32'h0605_0403);
        check("ld3_lat", last_lat, 5);

        do_op(1'b1, 16'h0020, 2'b01, 1'b0, 32'h0000_7F80);
        do_op(1'b0, 16'h0020, 2'b00, 1'b1, 32'h0);
        check("sbyte", last_rdata, 32'hFFFF_FF80);
        do_op(1'b0, 16'h0020, 2'b00, 1'b0, 32'h0);
        check("ubyte", last_rdata, 32'h0000_0080);
        do_op(1'b0, 16'h0020, 2'b10, 1'b1, 32'h0);
        check("shalf", last_rdata, 32'h0000_7F80);

        do_op(1'b1, 16'hFFFF, 2'b01, 1'b0, 32'h0000_BEEF);
        check("wrap_lat", last_lat, 3);
        check("wrap_ffff", {24'd0, rd_mem(16'hFFFF)}, 32'hEF);
        check("wrap_0000", {24'd0, rd_mem(16'h0000)}, 32'hBE);

        // Non-splitting instance: misaligned reject, then an aligned byte load
        @(negedge clk);
        req0 = 1'b1; write0 = 1'b0; addr0 = 16'h0002; size0 = 2'b11; sgn0 = 1'b0;
        @(posedge clk);
        #1 req0 = 1'b0;
        @(negedge clk);
        check("rej_done", {31'd0, done0}, 32'd1);
        check("rej_err", {31'd0, err0}, 32'd1);
        check("rej_rdata", rdata0, 32'd0);
        check("rej_mwe", {31'd0, mwe0}, 32'd1);
        @(negedge clk);
        check("rej_pulse", {31'd0, done0}, 32'd0);
        check("rej_mwe2", {31'd0, mwe0}, 32'd1);
        req0 = 1'b1; addr0 = 16'h0005; size0 = 2'b00; sgn0 = 1'b1;
        @(posedge clk);
        #1 req0 = 1'b0;
        @(negedge clk);
        check("d0_xfer_nodone", {31'd0, done0}, 32'd0);
        @(negedge clk);
        check("d0_done", {31'd0, done0}, 32'd1);
        check("d0_rdata", rdata0, 32'hFFFF_FFEF);

        // Reset during byte 2 of a split word store at 0x0101
        @(negedge clk);
        req = 1'b1; write = 1'b1; addr = 16'h0101; size = 2'b11; sgn = 1'b0; wdata = 32'hA1B2_C3D4;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_addr", {16'd0, maddr}, 32'h0103);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ready", {31'd0, ready}, 32'd1);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_mwe", {31'd0, mwe}, 32'd1);
        check("rst_mid_maddr", {16'd0, maddr}, 32'd0);
        check("rst_mid_mdata", mdata, 32'd0);
        ref_mem[16'h0101] = 8'hD4;
        ref_mem[16'h0102] = 8'hC3;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_done", {31'd0, done}, 32'd0);
        end
        for (int a = 16'h0101; a <= 16'h0104; a++)
            check("rst_mem", {24'd0, rd_mem(16'(a))}, {24'd0, ref_mem[16'(a)]});
        do_op(1'b0, 16'h0101, 2'b11, 1'b0, 32'h0);

        for (int i = 0; i < 60; i++) begin
            wd = $urandom;
            do_op(1'($urandom), 16'hFFF8 + 16'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  1'($urandom), wd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
